// File: rtl/aes_pkg.sv
// Shared AES definitions: block geometry, S-box, GF(2^8) doubling, sequencer states.
// State bytes are column-major: byte i = row (i%4), column (i/4), and byte 0 sits in bits [127:120].
package aes_pkg;

  localparam int Nb = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } seqState_e;

  // Element 0 of the packed array is the leftmost literal byte, so SboxTab[b] is S(b).
  localparam logic [0:255][7:0] SboxTab = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  function automatic logic [7:0] sbox(input logic [7:0] b);
    return SboxTab[b];
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic int nr_of(input int nk);
    return nk + 6;
  endfunction

endpackage

// File: rtl/aes_round_comb.sv
// One combinational AES encryption round: SubBytes, ShiftRows, optional MixColumns, AddRoundKey.
module aes_round_comb
  import aes_pkg::*;
(
  input  logic [127:0] state_in,
  input  logic [127:0] rk,
  input  logic         last,
  output logic [127:0] state_out
);

  logic [127:0] subBytes;
  logic [127:0] shiftRows;
  logic [127:0] mixColumns;

  for (genvar i = 0; i < 16; i++) begin : g_sub
    assign subBytes[127-8*i -: 8] = sbox(state_in[127-8*i -: 8]);
  end

  for (genvar c = 0; c < Nb; c++) begin : g_col
    logic [7:0] a0, a1, a2, a3;

    // Row r rotates left by r columns.
    for (genvar r = 0; r < 4; r++) begin : g_row
      assign shiftRows[127-8*(r+4*c) -: 8] = subBytes[127-8*(r+4*((c+r)%4)) -: 8];
    end

    assign a0 = shiftRows[127-32*c -: 8];
    assign a1 = shiftRows[119-32*c -: 8];
    assign a2 = shiftRows[111-32*c -: 8];
    assign a3 = shiftRows[103-32*c -: 8];

    assign mixColumns[127-32*c -: 32] = {
      xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
      a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
      a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
      xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)
    };
  end

  assign state_out = (last ? shiftRows : mixColumns) ^ rk;

endmodule

// File: rtl/aes_round_sequencer.sv
// Iterative AES encryptor: one round per clock through a shared round datapath,
// with valid/ready handshakes on plaintext in and ciphertext out.
module aes_round_sequencer
  import aes_pkg::*;
#(
  parameter int Nk = 4,
  parameter int Nr = nr_of(Nk)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [127:0]            plain_text,
  input  logic [128*(Nr+1)-1:0]   round_keys,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [127:0]            cipher_text,
  output logic                    busy
);

  localparam int RoundW = $clog2(Nr + 1);

  seqState_e         fsm;
  logic [RoundW-1:0] round;
  logic [127:0]      stateReg;
  logic              idleFlag;
  logic              outValidReg;
  logic              busyReg;

  logic [127:0]      rkArr [Nr+1];
  logic [127:0]      roundKey;
  logic [127:0]      roundOut;
  logic              lastRound;

  for (genvar i = 0; i <= Nr; i++) begin : g_rk
    assign rkArr[i] = round_keys[128*(Nr+1)-1-128*i -: 128];
  end

  // Explicit compare-mux so counter codes above Nr can never select a key.
  always_comb begin
    roundKey = rkArr[0];
    for (int i = 1; i <= Nr; i++) begin
      if (round == RoundW'(i)) roundKey = rkArr[i];
    end
  end

  assign lastRound = (round == RoundW'(Nr));

  aes_round_comb roundComb (
    .state_in (stateReg),
    .rk       (roundKey),
    .last     (lastRound),
    .state_out(roundOut)
  );

  // DONE with out_ready may hand off and accept the next block on the same edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fsm         <= IDLE;
      round       <= '0;
      stateReg    <= '0;
      idleFlag    <= 1'b1;
      outValidReg <= 1'b0;
      busyReg     <= 1'b0;
    end else begin
      case (fsm)
        IDLE: begin
          if (in_valid) begin
            stateReg <= plain_text ^ rkArr[0];
            round    <= RoundW'(1);
            fsm      <= RUN;
            idleFlag <= 1'b0;
            busyReg  <= 1'b1;
          end
        end
        RUN: begin
          stateReg <= roundOut;
          if (lastRound) begin
            round       <= '0;
            fsm         <= DONE;
            busyReg     <= 1'b0;
            outValidReg <= 1'b1;
          end else begin
            round <= round + 1'b1;
          end
        end
        DONE: begin
          if (out_ready) begin
            outValidReg <= 1'b0;
            if (in_valid) begin
              stateReg <= plain_text ^ rkArr[0];
              round    <= RoundW'(1);
              fsm      <= RUN;
              busyReg  <= 1'b1;
            end else begin
              fsm      <= IDLE;
              idleFlag <= 1'b1;
            end
          end
        end
        default: begin
          fsm         <= IDLE;
          round       <= '0;
          idleFlag    <= 1'b1;
          outValidReg <= 1'b0;
          busyReg     <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready    = idleFlag | (outValidReg & out_ready);
  assign out_valid   = outValidReg;
  assign busy        = busyReg;
  assign cipher_text = stateReg;

endmodule

// File: tb/tb_aes_round_sequencer.sv
// Self-checking bench for aes_round_sequencer: AES-128 and AES-256 instances against
// FIPS-197 vectors and an independent behavioural AES model, with a result scoreboard.
module tb_aes_round_sequencer;

  typedef struct {
    int           sel;
    logic [255:0] key;
    logic [127:0] pt;
    logic [127:0] exp;
  } vec_t;

  logic               clk = 1'b0;
  logic               rst_n;
  logic [1:0]         inValid, inReady, outValid, outReady, busy, prevOutValid;
  logic [1:0][127:0]  plainText, cipherText;
  logic [1407:0]      rk128;
  logic [1919:0]      rk256;

  logic [7:0]         sbTab [256];
  logic [127:0]       expQ [$];
  int                 accQ [$];
  int                 accLog [$];
  logic [127:0]       pendingExp;
  int                 cycleCnt = 0;
  int                 compared = 0;
  int                 mismatched = 0;

  aes_round_sequencer #(.Nk(4)) dut128 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(inValid[0]), .in_ready(inReady[0]), .plain_text(plainText[0]),
    .round_keys(rk128),
    .out_valid(outValid[0]), .out_ready(outReady[0]), .cipher_text(cipherText[0]),
    .busy(busy[0])
  );

  aes_round_sequencer #(.Nk(8)) dut256 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(inValid[1]), .in_ready(inReady[1]), .plain_text(plainText[1]),
    .round_keys(rk256),
    .out_valid(outValid[1]), .out_ready(outReady[1]), .cipher_text(cipherText[1]),
    .busy(busy[1])
  );

  always #5 clk = ~clk;

  always @(posedge clk) cycleCnt++;

  // Shift-and-add GF(2^8) multiply, used to build the S-box from first principles.
  function automatic logic [7:0] gfMul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = x[7] ? ({x[6:0], 1'b0} ^ 8'h1b) : {x[6:0], 1'b0};
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
    return (b << n) | (b >> (8 - n));
  endfunction

  task automatic buildSbox();
    logic [7:0] inv;
    for (int x = 0; x < 256; x++) begin
      inv = 8'h00;
      for (int y = 1; y < 256; y++) begin
        if (gfMul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      end
      sbTab[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
    end
  endtask

  function automatic logic [31:0] subWord(input logic [31:0] w);
    return {sbTab[w[31:24]], sbTab[w[23:16]], sbTab[w[15:8]], sbTab[w[7:0]]};
  endfunction

  // Returns the schedule left-aligned in 1920 bits, round key 0 in the MSBs.
  function automatic logic [1919:0] expandKey(input logic [255:0] key, input int nk);
    logic [31:0]   w [60];
    logic [31:0]   t;
    logic [7:0]    rcon;
    logic [1919:0] r;
    int            nr;
    nr = nk + 6;
    rcon = 8'h01;
    r = '0;
    for (int i = 0; i < 4 * (nr + 1); i++) begin
      if (i < nk) begin
        w[i] = key[255-32*i -: 32];
      end else begin
        t = w[i-1];
        if (i % nk == 0) begin
          t = subWord({t[23:0], t[31:24]}) ^ {rcon, 24'h000000};
          rcon = gfMul(rcon, 8'h02);
        end else if (nk > 6 && i % nk == 4) begin
          t = subWord(t);
        end
        w[i] = w[i-nk] ^ t;
      end
      r[1919-32*i -: 32] = w[i];
    end
    return r;
  endfunction

  function automatic logic [127:0] encrypt(input logic [127:0] pt, input logic [1919:0] rks, input int nk);
    logic [7:0]   s [16];
    logic [7:0]   t [16];
    logic [7:0]   a0, a1, a2, a3;
    logic [127:0] res;
    int           nr;
    nr = nk + 6;
    for (int i = 0; i < 16; i++) s[i] = pt[127-8*i -: 8] ^ rks[1919-8*i -: 8];
    for (int rnd = 1; rnd <= nr; rnd++) begin
      for (int i = 0; i < 16; i++) t[i] = sbTab[s[i]];
      for (int c = 0; c < 4; c++)
        for (int row = 0; row < 4; row++) s[row+4*c] = t[row+4*((c+row)%4)];
      if (rnd != nr) begin
        for (int c = 0; c < 4; c++) begin
          a0 = s[4*c]; a1 = s[4*c+1]; a2 = s[4*c+2]; a3 = s[4*c+3];
          s[4*c]   = gfMul(8'h02, a0) ^ gfMul(8'h03, a1) ^ a2 ^ a3;
          s[4*c+1] = a0 ^ gfMul(8'h02, a1) ^ gfMul(8'h03, a2) ^ a3;
          s[4*c+2] = a0 ^ a1 ^ gfMul(8'h02, a2) ^ gfMul(8'h03, a3);
          s[4*c+3] = gfMul(8'h03, a0) ^ a1 ^ a2 ^ gfMul(8'h02, a3);
        end
      end
      for (int i = 0; i < 16; i++) s[i] = s[i] ^ rks[1919-128*rnd-8*i -: 8];
    end
    for (int i = 0; i < 16; i++) res[127-8*i -: 8] = s[i];
    return res;
  endfunction

  function automatic void checkOutput(input string name, input logic [127:0] act, input logic [127:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got %h, required %h", name, act, exp);
    end
  endfunction

  task automatic applyStimulus(input int sel, input logic [127:0] pt, input logic [127:0] exp);
    bit done;
    done = 1'b0;
    @(posedge clk); #1;
    plainText[sel] = pt;
    pendingExp     = exp;
    inValid[sel]   = 1'b1;
    for (int i = 0; i < 100 && !done; i++) begin
      @(negedge clk);
      if (inReady[sel]) done = 1'b1;
    end
    @(posedge clk); #1;
    inValid[sel] = 1'b0;
    if (!done) begin
      compared++;
      mismatched++;
      $display("[TB] FAIL accept-timeout: dut%0d in_ready never rose, required 1", sel);
    end
  endtask

  task automatic waitDrain(input int bound);
    int i;
    i = 0;
    while (expQ.size() != 0 && i < bound) begin
      @(negedge clk);
      i++;
    end
    if (expQ.size() != 0) begin
      compared++;
      mismatched++;
      $display("[TB] FAIL drain-timeout: %0d results outstanding, required 0", expQ.size());
      expQ.delete();
      accQ.delete();
    end
  endtask

  // Scoreboard: expected result queued on each accept, compared on each output handshake.
  always @(negedge clk) begin
    if (rst_n) begin
      for (int s = 0; s < 2; s++) begin
        if (inValid[s] && inReady[s]) begin
          expQ.push_back(pendingExp);
          accQ.push_back(cycleCnt);
          accLog.push_back(cycleCnt);
        end
        if (outValid[s] && !prevOutValid[s]) begin
          if (accQ.size() == 0) begin
            compared++;
            mismatched++;
            $display("[TB] FAIL latency: dut%0d out_valid rose with no accepted block", s);
          end else begin
            checkOutput("latency", 128'(cycleCnt - accQ.pop_front()), 128'((s == 1) ? 15 : 11));
          end
        end
        if (outValid[s] && outReady[s]) begin
          if (expQ.size() == 0) begin
            compared++;
            mismatched++;
            $display("[TB] FAIL unexpected-output: dut%0d produced %h, required none", s, cipherText[s]);
          end else begin
            checkOutput("ciphertext", cipherText[s], expQ.pop_front());
          end
        end
      end
    end
    prevOutValid = outValid;
  end

  initial begin
    #400000;
    $display("[TB] FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    vec_t          vecs [3];
    logic [1919:0] fullKey;
    logic [1919:0] c1Keys;
    logic [127:0]  ptA, exA, ptB, exB;
    logic [127:0]  pts [4];
    logic [127:0]  exps [4];
    logic [127:0]  rndKey;
    int            idx;
    int            n;

    rst_n = 1'b0;
    inValid = '0;
    outReady = '0;
    plainText = '0;
    pendingExp = '0;
    rk128 = '0;
    rk256 = '0;
    prevOutValid = '0;
    buildSbox();

    vecs[0].sel = 0;
    vecs[0].key = {128'h000102030405060708090a0b0c0d0e0f, 128'h0};
    vecs[0].pt  = 128'h00112233445566778899aabbccddeeff;
    vecs[0].exp = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    vecs[1].sel = 0;
    vecs[1].key = {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0};
    vecs[1].pt  = 128'h3243f6a8885a308d313198a2e0370734;
    vecs[1].exp = 128'h3925841d02dc09fbdc118597196a0b32;
    vecs[2].sel = 1;
    vecs[2].key = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
    vecs[2].pt  = 128'h00112233445566778899aabbccddeeff;
    vecs[2].exp = 128'h8ea2b7ca516745bfeafc49904b496089;

    c1Keys = expandKey(vecs[0].key, 4);

    // Reset state of both instances
    @(negedge clk);
    for (int s = 0; s < 2; s++) begin
      checkOutput($sformatf("reset-in_ready%0d", s), 128'(inReady[s]), 128'd1);
      checkOutput($sformatf("reset-out_valid%0d", s), 128'(outValid[s]), 128'd0);
      checkOutput($sformatf("reset-busy%0d", s), 128'(busy[s]), 128'd0);
      checkOutput($sformatf("reset-cipher%0d", s), cipherText[s], 128'd0);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    outReady = 2'b11;

    // Known-answer vectors
    for (int v = 0; v < 3; v++) begin
      fullKey = expandKey(vecs[v].key, (vecs[v].sel == 1) ? 8 : 4);
      if (vecs[v].sel == 0) rk128 = fullKey[1919 -: 1408];
      else rk256 = fullKey;
      applyStimulus(vecs[v].sel, vecs[v].pt, vecs[v].exp);
      waitDrain(40);
    end

    // One random AES-256 block against the model
    rndKey = {$urandom, $urandom, $urandom, $urandom};
    fullKey = expandKey({rndKey, ~rndKey}, 8);
    rk256 = fullKey;
    ptA = {$urandom, $urandom, $urandom, $urandom};
    applyStimulus(1, ptA, encrypt(ptA, fullKey, 8));
    waitDrain(40);

    // Backpressure: result must hold for 5 cycles with out_ready low
    rk128 = c1Keys[1919 -: 1408];
    outReady[0] = 1'b0;
    ptA = {$urandom, $urandom, $urandom, $urandom};
    exA = encrypt(ptA, c1Keys, 4);
    applyStimulus(0, ptA, exA);
    n = 0;
    while (!outValid[0] && n < 40) begin
      @(negedge clk);
      n++;
    end
    checkOutput("bp-valid-rise", 128'(outValid[0]), 128'd1);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checkOutput("bp-valid-held", 128'(outValid[0]), 128'd1);
      checkOutput("bp-in_ready", 128'(inReady[0]), 128'd0);
      checkOutput("bp-cipher-stable", cipherText[0], exA);
    end
    @(posedge clk); #1;
    outReady[0] = 1'b1;
    @(negedge clk);
    @(negedge clk);
    checkOutput("bp-release-valid", 128'(outValid[0]), 128'd0);
    checkOutput("bp-release-in_ready", 128'(inReady[0]), 128'd1);
    waitDrain(5);

    // Back-to-back: in_valid and out_ready held high across 4 random blocks
    rndKey = {$urandom, $urandom, $urandom, $urandom};
    fullKey = expandKey({rndKey, 128'h0}, 4);
    rk128 = fullKey[1919 -: 1408];
    for (int i = 0; i < 4; i++) begin
      pts[i]  = {$urandom, $urandom, $urandom, $urandom};
      exps[i] = encrypt(pts[i], fullKey, 4);
    end
    accLog.delete();
    idx = 0;
    @(posedge clk); #1;
    plainText[0] = pts[0];
    pendingExp = exps[0];
    inValid[0] = 1'b1;
    for (int cyc = 0; cyc < 200 && idx < 4; cyc++) begin
      @(negedge clk);
      if (inReady[0]) idx++;
      @(posedge clk); #1;
      if (idx < 4) begin
        plainText[0] = pts[idx];
        pendingExp = exps[idx];
      end
    end
    inValid[0] = 1'b0;
    checkOutput("b2b-accepts", 128'(idx), 128'd4);
    waitDrain(40);
    if (accLog.size() == 4) begin
      for (int i = 1; i < 4; i++)
        checkOutput("b2b-interval", 128'(accLog[i] - accLog[i-1]), 128'd11);
    end else begin
      compared++;
      mismatched++;
      $display("[TB] FAIL b2b-accept-log: %0d accepts logged, required 4", accLog.size());
    end

    // Reset asserted at round 5 discards the block
    rk128 = c1Keys[1919 -: 1408];
    ptA = {$urandom, $urandom, $urandom, $urandom};
    applyStimulus(0, ptA, encrypt(ptA, c1Keys, 4));
    repeat (3) @(posedge clk);
    @(negedge clk);
    checkOutput("mid-busy", 128'(busy[0]), 128'd1);
    @(posedge clk); #1;
    rst_n = 1'b0;
    expQ.delete();
    accQ.delete();
    @(negedge clk);
    checkOutput("rst-out_valid", 128'(outValid[0]), 128'd0);
    checkOutput("rst-busy", 128'(busy[0]), 128'd0);
    checkOutput("rst-in_ready", 128'(inReady[0]), 128'd1);
    @(posedge clk); #1;
    rst_n = 1'b1;
    applyStimulus(0, vecs[0].pt, vecs[0].exp);
    waitDrain(40);

    // in_valid pulsed during RUN must be ignored
    ptA = {$urandom, $urandom, $urandom, $urandom};
    exA = encrypt(ptA, c1Keys, 4);
    ptB = ~ptA;
    exB = encrypt(ptB, c1Keys, 4);
    applyStimulus(0, ptA, exA);
    repeat (2) @(posedge clk);
    #1;
    plainText[0] = ptB;
    pendingExp = exB;
    inValid[0] = 1'b1;
    @(negedge clk);
    checkOutput("run-in_ready", 128'(inReady[0]), 128'd0);
    @(posedge clk); #1;
    inValid[0] = 1'b0;
    waitDrain(40);
    repeat (20) @(negedge clk);
    checkOutput("ignored-no-extra-block", 128'(busy[0] | outValid[0]), 128'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
